// File: rtl/systolic_ctrl.sv
// systolic_ctrl: operand sequencer and result capture for the NxN FP-INT systolic array.
// Optional watchdog in WAIT_DONE enabled by defining SYSTOLIC_CTRL_TIMEOUT_EN.
module systolic_ctrl #(
  parameter int ACT_WIDTH   = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int N           = 2,
  parameter int K_MAX       = 16,
  parameter int PREC_MAX    = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(K_MAX)-1:0]     wr_addr,
  input  logic [N*ACT_WIDTH-1:0]       wr_act,
  input  logic [N*PREC_MAX-1:0]        wr_w,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [$clog2(K_MAX+1)-1:0]   k_len,
  input  logic [3:0]                   precision,
  input  logic [4:0]                   exp_set,
  output logic                         cfg_err,
  output logic                         busy,
  output logic                         arr_active,
  output logic [3:0]                   arr_precision,
  output logic [4:0]                   arr_exp_set,
  output logic [N*ACT_WIDTH-1:0]       arr_act_in,
  output logic [N-1:0]                 arr_w_in,
  input  logic                         arr_done,
  input  logic [N*N*ACC_WIDTH-1:0]     arr_acc_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [N*N*ACC_WIDTH-1:0]     res_acc,
  output logic                         res_timeout
);
  localparam int KW = $clog2(K_MAX);
  localparam int LW = $clog2(K_MAX+1);
  localparam int BW = $clog2(PREC_MAX);
  localparam logic [LW-1:0] KMAX_L = LW'(K_MAX);
  localparam logic [3:0] PMAX_L = 4'(PREC_MAX);

  if (PREC_MAX > 15 || PREC_MAX < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("systolic_ctrl: unsupported PREC_MAX/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE, RESULT} state_t;

  logic [N*ACT_WIDTH-1:0] act_mem [K_MAX];
  logic [N*PREC_MAX-1:0]  w_mem   [K_MAX];

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [LW-1:0]          klen_q, klen_d;
  logic [3:0]             prec_q, prec_d;
  logic [4:0]             exp_q, exp_d;
  logic                   active_q, active_d;
  logic [N*ACT_WIDTH-1:0] act_q, act_d;
  logic [N-1:0]           w_q, w_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   res_valid_q, res_valid_d;
  logic [N*N*ACC_WIDTH-1:0] res_acc_q, res_acc_d;
  logic                   legal;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   res_to_q, res_to_d;
`endif

  assign legal = k_len != '0 && k_len <= KMAX_L && precision != 4'd0 && precision <= PMAX_L;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) begin
      act_mem[wr_addr] <= wr_act;
      w_mem[wr_addr]   <= wr_w;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    bit_d       = bit_q;
    klen_d      = klen_q;
    prec_d      = prec_q;
    exp_d       = exp_q;
    cfg_err_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_acc_d   = res_acc_q;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    cnt_d       = '0;
    res_to_d    = res_to_q;
`endif
    case (state_q)
      IDLE: if (start_valid) begin
        if (legal) begin
          state_d = STREAM;
          klen_d  = k_len;
          prec_d  = precision;
          exp_d   = exp_set;
          k_d     = '0;
          bit_d   = BW'(precision - 4'd1);
        end else cfg_err_d = 1'b1;
      end
      STREAM: if (bit_q != '0) bit_d = bit_q - BW'(1);
      else if (LW'(k_q) + LW'(1) == klen_q) state_d = WAIT_DONE;
      else begin
        k_d   = k_q + KW'(1);
        bit_d = BW'(prec_q - 4'd1);
      end
      WAIT_DONE: if (arr_done) begin
        state_d     = RESULT;
        res_valid_d = 1'b1;
        res_acc_d   = arr_acc_out;
      end
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
      else if (cnt_q == TW'(TIMEOUT_CYC-1)) begin
        state_d     = RESULT;
        res_valid_d = 1'b1;
        res_acc_d   = '0;
        res_to_d    = 1'b1;
      end else cnt_d = cnt_q + TW'(1);
`endif
      RESULT: if (res_ready) begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
        res_to_d    = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
    // array drive is registered, so it is computed from the next position
    active_d = state_d == STREAM;
    act_d    = active_d ? act_mem[k_d] : '0;
    for (int j = 0; j < N; j++) w_d[j] = active_d & w_mem[k_d][j*PREC_MAX + int'(bit_d)];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      bit_q       <= '0;
      klen_q      <= '0;
      prec_q      <= '0;
      exp_q       <= '0;
      active_q    <= 1'b0;
      act_q       <= '0;
      w_q         <= '0;
      cfg_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_acc_q   <= '0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
      cnt_q       <= '0;
      res_to_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      bit_q       <= bit_d;
      klen_q      <= klen_d;
      prec_q      <= prec_d;
      exp_q       <= exp_d;
      active_q    <= active_d;
      act_q       <= act_d;
      w_q         <= w_d;
      cfg_err_q   <= cfg_err_d;
      res_valid_q <= res_valid_d;
      res_acc_q   <= res_acc_d;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
      cnt_q       <= cnt_d;
      res_to_q    <= res_to_d;
`endif
    end
  end

  assign start_ready   = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign cfg_err       = cfg_err_q;
  assign arr_active    = active_q;
  assign arr_precision = prec_q;
  assign arr_exp_set   = exp_q;
  assign arr_act_in    = act_q;
  assign arr_w_in      = w_q;
  assign res_valid     = res_valid_q;
  assign res_acc       = res_acc_q;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  assign res_timeout   = res_to_q;
`else
  assign res_timeout   = 1'b0;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed self-checking bench for systolic_ctrl (N=2, K_MAX=16, PREC_MAX=8).
module tb_systolic_ctrl;
  logic         clk = 0, rst = 0, wr_en = 0, start_valid = 0, arr_done = 0, res_ready = 0;
  logic [3:0]   wr_addr = 0, precision = 0;
  logic [31:0]  wr_act = 0;
  logic [15:0]  wr_w = 0;
  logic [4:0]   k_len = 0, exp_set = 0;
  logic [127:0] arr_acc_out = 0;
  logic         start_ready, cfg_err, busy, arr_active, res_valid, res_timeout;
  logic [3:0]   arr_precision;
  logic [4:0]   arr_exp_set;
  logic [31:0]  arr_act_in;
  logic [1:0]   arr_w_in;
  logic [127:0] res_acc;
  int total = 0, bad = 0;

  systolic_ctrl #(.ACT_WIDTH(16), .ACC_WIDTH(32), .N(2), .K_MAX(16), .PREC_MAX(8), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_act(wr_act), .wr_w(wr_w),
    .start_valid(start_valid), .start_ready(start_ready), .k_len(k_len), .precision(precision),
    .exp_set(exp_set), .cfg_err(cfg_err), .busy(busy), .arr_active(arr_active),
    .arr_precision(arr_precision), .arr_exp_set(arr_exp_set), .arr_act_in(arr_act_in),
    .arr_w_in(arr_w_in), .arr_done(arr_done), .arr_acc_out(arr_acc_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_acc(res_acc), .res_timeout(res_timeout));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic wr(input logic [3:0] a, input logic [31:0] act, input logic [15:0] w);
    wr_en = 1; wr_addr = a; wr_act = act; wr_w = w;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic go(input logic [4:0] kl, input logic [3:0] p, input logic [4:0] e);
    start_valid = 1; k_len = kl; precision = p; exp_set = e;
    @(negedge clk);
    start_valid = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    @(negedge clk); @(negedge clk);
    total++; if ({busy, arr_active, res_valid, cfg_err, res_timeout} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {busy, arr_active, res_valid, cfg_err, res_timeout}); end
    total++; if ({arr_act_in, arr_w_in, arr_precision, arr_exp_set} !== '0) begin bad++; $display("FAIL reset_arr got=%h want=0", {arr_act_in, arr_w_in, arr_precision, arr_exp_set}); end
    total++; if (res_acc !== '0) begin bad++; $display("FAIL reset_res_acc got=%h want=0", res_acc); end
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%b want=1", start_ready); end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0]  row0;
    logic [127:0] acc;
    acc = {32'hFFFFAC00, 32'hFFFFAC00, 32'hFFFF9000, 32'hFFFF9000};
    wr(4'd0, {16'h4000, 16'h3C00}, {8'h0F, 8'h0F});
    wr(4'd1, {16'h0000, 16'h4200}, {8'h0F, 8'h0F});
    go(5'd2, 4'd4, 5'd15);
    for (int i = 0; i < 8; i++) begin
      row0 = (i < 4) ? 16'h3C00 : 16'h4200;
      total++; if (arr_active !== 1'b1) begin bad++; $display("FAIL basic_active cyc=%0d got=%b want=1", i, arr_active); end
      total++; if (arr_act_in[15:0] !== row0) begin bad++; $display("FAIL basic_row0 cyc=%0d got=%h want=%h", i, arr_act_in[15:0], row0); end
      total++; if (arr_w_in !== 2'b11) begin bad++; $display("FAIL basic_w cyc=%0d got=%b want=11", i, arr_w_in); end
      if (i == 0) begin
        total++; if (arr_act_in[31:16] !== 16'h4000) begin bad++; $display("FAIL basic_row1 got=%h want=4000", arr_act_in[31:16]); end
        total++; if ({arr_precision, arr_exp_set} !== {4'd4, 5'd15}) begin bad++; $display("FAIL basic_latched got=%0d/%0d want=4/15", arr_precision, arr_exp_set); end
      end
      @(negedge clk);
    end
    total++; if ({arr_active, arr_act_in, arr_w_in} !== '0) begin bad++; $display("FAIL basic_wait_drive got=%b/%h/%b want=0", arr_active, arr_act_in, arr_w_in); end
    total++; if (busy !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL basic_wait_state busy=%b res_valid=%b want=1/0", busy, res_valid); end
    arr_done = 1; arr_acc_out = acc;
    @(negedge clk);
    arr_done = 0;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL basic_res_valid got=%b want=1", res_valid); end
    total++; if (res_acc !== acc) begin bad++; $display("FAIL basic_res_acc got=%h want=%h", res_acc, acc); end
    total++; if (res_acc[31:0] !== 32'hFFFF9000) begin bad++; $display("FAIL basic_pe00 got=%h want=FFFF9000", res_acc[31:0]); end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    total++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin bad++; $display("FAIL basic_handshake res_valid=%b start_ready=%b want=0/1", res_valid, start_ready); end
    total++; if (arr_precision !== 4'd4) begin bad++; $display("FAIL basic_prec_hold got=%0d want=4", arr_precision); end
  endtask

  task automatic test_bit_order;
    logic [3:0] pat;
    pat = 4'b1010;
    wr(4'd0, {16'h0000, 16'h3C00}, {8'h00, 8'h0A});
    go(5'd1, 4'd4, 5'd0);
    for (int i = 0; i < 4; i++) begin
      total++; if (arr_w_in !== {1'b0, pat[3-i]}) begin bad++; $display("FAIL bitorder cyc=%0d got=%b want=%b", i, arr_w_in, {1'b0, pat[3-i]}); end
      @(negedge clk);
    end
    arr_done = 1;
    @(negedge clk);
    arr_done = 0;
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bitorder_res_valid got=%b want=1", res_valid); end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_illegal;
    logic [4:0] kl [4];
    logic [3:0] pr [4];
    kl = '{5'd1, 5'd0, 5'd17, 5'd2};
    pr = '{4'd0, 4'd4, 4'd4, 4'd9};
    for (int c = 0; c < 4; c++) begin
      start_valid = 1; k_len = kl[c]; precision = pr[c];
      @(negedge clk);
      start_valid = 0;
      total++; if (cfg_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL illegal_pulse case=%0d cfg_err=%b busy=%b want=1/0", c, cfg_err, busy); end
      @(negedge clk);
      total++; if (cfg_err !== 1'b0 || busy !== 1'b0 || arr_active !== 1'b0) begin bad++; $display("FAIL illegal_after case=%0d cfg_err=%b busy=%b active=%b want=0/0/0", c, cfg_err, busy, arr_active); end
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] a, b;
    a = 128'h11111111_22222222_33333333_44444444;
    b = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    wr(4'd0, {16'h1111, 16'h2222}, {8'h01, 8'h02});
    arr_done = 1; arr_acc_out = a;
    go(5'd1, 4'd2, 5'd3);
    total++; if (arr_active !== 1'b1) begin bad++; $display("FAIL bp_stream0 got=%b want=1", arr_active); end
    @(negedge clk);
    total++; if (arr_active !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_done_ignored active=%b res_valid=%b want=1/0", arr_active, res_valid); end
    @(negedge clk);
    @(negedge clk);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bp_res_valid got=%b want=1", res_valid); end
    arr_done = 0; arr_acc_out = b;
    start_valid = 1; k_len = 5'd1; precision = 4'd1; exp_set = 5'd9;
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1 || res_acc !== a) begin bad++; $display("FAIL bp_hold cyc=%0d res_valid=%b res_acc=%h want=1/%h", i, res_valid, res_acc, a); end
      total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL bp_start_ready cyc=%0d got=%b want=0", i, start_ready); end
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin bad++; $display("FAIL bp_release res_valid=%b busy=%b start_ready=%b want=0/0/1", res_valid, busy, start_ready); end
    @(negedge clk);
    start_valid = 0;
    total++; if (busy !== 1'b1 || arr_active !== 1'b1 || arr_precision !== 4'd1 || arr_exp_set !== 5'd9) begin bad++; $display("FAIL bp_second_accept busy=%b active=%b prec=%0d exp=%0d want=1/1/1/9", busy, arr_active, arr_precision, arr_exp_set); end
    @(negedge clk);
    arr_done = 1;
    @(negedge clk);
    arr_done = 0;
    total++; if (res_valid !== 1'b1 || res_acc !== b) begin bad++; $display("FAIL bp_second_result res_valid=%b res_acc=%h want=1/%h", res_valid, res_acc, b); end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
  endtask

  task automatic test_reset_mid;
    wr(4'd0, {16'h5555, 16'h6666}, {8'h0F, 8'h0F});
    go(5'd1, 4'd4, 5'd7);
    @(negedge clk);
    total++; if (arr_active !== 1'b1 || arr_w_in !== 2'b11) begin bad++; $display("FAIL rstmid_pre active=%b w=%b want=1/11", arr_active, arr_w_in); end
    rst = 0;
    @(negedge clk);
    total++; if ({busy, arr_active, arr_w_in, res_valid, cfg_err, res_timeout} !== '0) begin bad++; $display("FAIL rstmid_flags got=%b want=0", {busy, arr_active, arr_w_in, res_valid, cfg_err, res_timeout}); end
    total++; if ({arr_act_in, arr_precision, arr_exp_set, res_acc} !== '0) begin bad++; $display("FAIL rstmid_data got=%h want=0", {arr_act_in, arr_precision, arr_exp_set}); end
    rst = 1;
    @(negedge clk);
    total++; if (start_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_after start_ready=%b busy=%b want=1/0", start_ready, busy); end
  endtask

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    arr_done = 0; arr_acc_out = 128'hDEAD;
    go(5'd1, 4'd1, 5'd0);
    @(negedge clk);
    n = 0;
    while (busy && !res_valid && n < 40) begin n++; @(negedge clk); end
    total++; if (n !== 16) begin bad++; $display("FAIL timeout_cycles got=%0d want=16", n); end
    total++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_acc !== '0) begin bad++; $display("FAIL timeout_result valid=%b to=%b acc=%h want=1/1/0", res_valid, res_timeout, res_acc); end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    total++; if (res_timeout !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL timeout_clear to=%b valid=%b want=0/0", res_timeout, res_valid); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_bit_order;
    test_illegal;
    test_backpressure;
    test_reset_mid;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
